// File: rtl/commit_retire_if.sv
// ROB-head to commit-stage bus plus the commit stage's RAT/pipeline outputs.
// Pure wiring, no latency of its own.
// No backpressure: the ROB acts on commit_rob_pop/commit_rob_pop_count in the same cycle.
interface commit_retire_if #(
    parameter int COMMIT_WIDTH     = 2,
    parameter int PHY_REG_ID_WIDTH = 7,
    parameter int ROB_ID_WIDTH     = 6,
    parameter int CNT_WIDTH        = $clog2(COMMIT_WIDTH + 1)
);
    localparam int CW = COMMIT_WIDTH;
    localparam int P  = PHY_REG_ID_WIDTH;

    logic [ROB_ID_WIDTH-1:0] rob_commit_head_id;
    logic                    rob_commit_empty;
    logic [CW-1:0]           rob_commit_valid;
    logic [CW-1:0]           rob_commit_finish;
    logic [CW-1:0]           rob_commit_has_exception;
    logic [CW-1:0]           rob_commit_rename_valid;
    logic [CW*P-1:0]         rob_commit_new_phy;
    logic [CW*P-1:0]         rob_commit_old_phy;
    logic [CW*32-1:0]        rob_commit_pc;

    logic                    commit_rob_pop;
    logic [CNT_WIDTH-1:0]    commit_rob_pop_count;
    logic [CW*P-1:0]         commit_rat_release_phy;
    logic [CW-1:0]           commit_rat_release_valid;
    logic [CW*P-1:0]         commit_rat_commit_phy;
    logic [CW-1:0]           commit_rat_commit_valid;
    logic                    commit_rat_restore;
    logic                    commit_flush;
    logic [31:0]             commit_exception_pc;
    logic                    commit_busy;
    logic [CNT_WIDTH-1:0]    commit_csrf_instret_add;

    // ROB/RAT side drives the head view and consumes the commit results
    modport master (
        output rob_commit_head_id, rob_commit_empty, rob_commit_valid, rob_commit_finish,
               rob_commit_has_exception, rob_commit_rename_valid, rob_commit_new_phy,
               rob_commit_old_phy, rob_commit_pc,
        input  commit_rob_pop, commit_rob_pop_count, commit_rat_release_phy,
               commit_rat_release_valid, commit_rat_commit_phy, commit_rat_commit_valid,
               commit_rat_restore, commit_flush, commit_exception_pc, commit_busy,
               commit_csrf_instret_add
    );

    // commit stage side
    modport slave (
        input  rob_commit_head_id, rob_commit_empty, rob_commit_valid, rob_commit_finish,
               rob_commit_has_exception, rob_commit_rename_valid, rob_commit_new_phy,
               rob_commit_old_phy, rob_commit_pc,
        output commit_rob_pop, commit_rob_pop_count, commit_rat_release_phy,
               commit_rat_release_valid, commit_rat_commit_phy, commit_rat_commit_valid,
               commit_rat_restore, commit_flush, commit_exception_pc, commit_busy,
               commit_csrf_instret_add
    );
endinterface

// File: rtl/commit_retire.sv
// In-order retirement at the ROB head; on exception flushes, drains younger entries, restores RAT.
// Strobes are combinational (0 cycles) from head inputs; flush/busy/restore are registered (+1).
// No backpressure accepted: ROB and RAT must absorb pops/releases every cycle; busy stalls rename.
module commit_retire #(
    parameter int COMMIT_WIDTH     = 2,
    parameter int PHY_REG_ID_WIDTH = 7,
    parameter int CNT_WIDTH        = $clog2(COMMIT_WIDTH + 1)
) (
    input logic           clk,
    input logic           rst,
    commit_retire_if.slave bus
);
    localparam int CW = COMMIT_WIDTH;
    localparam int P  = PHY_REG_ID_WIDTH;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        WALK    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    state_t state;

    logic                 flush_q;
    logic                 restore_q;
    logic                 busy_q;
    logic [31:0]          exc_pc_q;

    logic [CNT_WIDTH-1:0] pop_cnt;
    logic [CNT_WIDTH-1:0] ret_cnt;
    logic                 exc_take;
    logic [31:0]          exc_pc;
    logic                 stop;
    logic [CW-1:0]        rel_vld;
    logic [CW*P-1:0]      rel_phy;
    logic [CW-1:0]        cmt_vld;
    logic [CW*P-1:0]      cmt_phy;

    // Per-slot retire/drain decode; everything is held at 0 while reset is asserted
    always_comb begin
        pop_cnt  = '0;
        ret_cnt  = '0;
        exc_take = 1'b0;
        exc_pc   = '0;
        stop     = 1'b0;
        rel_vld  = '0;
        rel_phy  = '0;
        cmt_vld  = '0;
        cmt_phy  = '0;
        if (rst) begin
            case (state)
                NORMAL: begin
                    for (int i = 0; i < CW; i++) begin
                        if (!stop) begin
                            if (bus.rob_commit_valid[i] && bus.rob_commit_finish[i] &&
                                !bus.rob_commit_has_exception[i]) begin
                                ret_cnt = ret_cnt + CNT_WIDTH'(1);
                                if (bus.rob_commit_rename_valid[i]) begin
                                    rel_vld[i]         = 1'b1;
                                    rel_phy[i*P +: P]  = bus.rob_commit_old_phy[i*P +: P];
                                    cmt_vld[i]         = 1'b1;
                                    cmt_phy[i*P +: P]  = bus.rob_commit_new_phy[i*P +: P];
                                end
                            end else if (bus.rob_commit_valid[i] && bus.rob_commit_finish[i]) begin
                                // Excepting entry: its speculative mapping is discarded, so
                                // the new phy goes back to the free list and never commits.
                                exc_take = 1'b1;
                                exc_pc   = bus.rob_commit_pc[i*32 +: 32];
                                if (bus.rob_commit_rename_valid[i]) begin
                                    rel_vld[i]        = 1'b1;
                                    rel_phy[i*P +: P] = bus.rob_commit_new_phy[i*P +: P];
                                end
                                stop = 1'b1;
                            end else begin
                                stop = 1'b1;
                            end
                        end
                    end
                    pop_cnt = ret_cnt + CNT_WIDTH'(exc_take);
                end
                WALK: begin
                    if (!bus.rob_commit_empty) begin
                        for (int i = 0; i < CW; i++) begin
                            if (!stop) begin
                                if (bus.rob_commit_valid[i]) begin
                                    pop_cnt = pop_cnt + CNT_WIDTH'(1);
                                    if (bus.rob_commit_rename_valid[i]) begin
                                        rel_vld[i]        = 1'b1;
                                        rel_phy[i*P +: P] = bus.rob_commit_new_phy[i*P +: P];
                                    end
                                end else begin
                                    stop = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Flush/drain/restore sequencer with registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= NORMAL;
            flush_q   <= 1'b0;
            restore_q <= 1'b0;
            busy_q    <= 1'b0;
            exc_pc_q  <= '0;
        end else begin
            flush_q   <= 1'b0;
            restore_q <= 1'b0;
            case (state)
                NORMAL: begin
                    if (exc_take) begin
                        state    <= WALK;
                        flush_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        exc_pc_q <= exc_pc;
                    end
                end
                WALK: begin
                    if (bus.rob_commit_empty) begin
                        state     <= RESTORE;
                        restore_q <= 1'b1;
                    end
                end
                RESTORE: begin
                    state  <= NORMAL;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= NORMAL;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.commit_rob_pop           = (pop_cnt != '0);
    assign bus.commit_rob_pop_count     = pop_cnt;
    assign bus.commit_rat_release_phy   = rel_phy;
    assign bus.commit_rat_release_valid = rel_vld;
    assign bus.commit_rat_commit_phy    = cmt_phy;
    assign bus.commit_rat_commit_valid  = cmt_vld;
    assign bus.commit_rat_restore       = restore_q;
    assign bus.commit_flush             = flush_q;
    assign bus.commit_exception_pc      = exc_pc_q;
    assign bus.commit_busy              = busy_q;
    assign bus.commit_csrf_instret_add  = ret_cnt;
endmodule
